// File: rtl/sfx_voice_mixer.sv
// Multi-voice sound-effect player: per-voice ROM walkers, saturating gain mixer,
// and a small first-word-fall-through FIFO feeding the codec write handshake.
module sfx_voice_mixer #(
   parameter int NV         = 2,
   parameter int AW         = 15,
   parameter int LEN        = 32768,
   parameter int ROM_LAT    = 1,
   parameter int TICK_DIV   = 1024,
   parameter int GAIN_SHIFT = 4,
   parameter int FIFO_DEPTH = 4
) (
   input  logic             CLOCK_50,
   input  logic             reset,
   input  logic [NV-1:0]    trig,
   output logic [NV*AW-1:0] rom_addr,
   input  logic [NV*24-1:0] rom_q,
   input  logic             write_ready,
   output logic             write,
   output logic [23:0]      writedata_left,
   output logic [23:0]      writedata_right,
   output logic [NV-1:0]    busy,
   output logic             overflow
);

   localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int SW = 24 + $clog2(NV) + GAIN_SHIFT;
   localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam logic signed [SW-1:0] SAT_HI = {{(SW-23){1'b0}}, {23{1'b1}}};
   localparam logic signed [SW-1:0] SAT_LO = {{(SW-23){1'b1}}, {23{1'b0}}};

   typedef enum logic {S_IDLE, S_PLAY} voice_t;

   logic [TW-1:0] r_tick_cnt;
   logic          w_tick;

   assign w_tick = (r_tick_cnt == TW'(TICK_DIV - 1));

   always_ff @(posedge CLOCK_50) begin
      if (reset)       r_tick_cnt <= '0;
      else if (w_tick) r_tick_cnt <= '0;
      else             r_tick_cnt <= r_tick_cnt + TW'(1);
   end

   logic signed [SW-1:0] w_term [NV];

   genvar gi;
   generate
      for (gi = 0; gi < NV; gi++) begin : g_voice
         voice_t        r_state, w_state_next;
         logic [AW-1:0] r_addr, w_addr_next;
         logic [AW-1:0] r_rom_addr;
         logic          r_act;

         // A trigger wins over the tick advance in the same cycle.
         always_comb begin
            w_state_next = r_state;
            w_addr_next  = r_addr;
            if (trig[gi]) begin
               w_state_next = S_PLAY;
               w_addr_next  = '0;
            end else if (w_tick && (r_state == S_PLAY)) begin
               if (r_addr == AW'(LEN - 1)) begin
                  w_state_next = S_IDLE;
                  w_addr_next  = '0;
               end else begin
                  w_addr_next = r_addr + AW'(1);
               end
            end
         end

         always_ff @(posedge CLOCK_50) begin
            if (reset) begin
               r_state    <= S_IDLE;
               r_addr     <= '0;
               r_rom_addr <= '0;
               r_act      <= 1'b0;
            end else begin
               r_state <= w_state_next;
               r_addr  <= w_addr_next;
               if (w_tick) begin
                  r_rom_addr <= r_addr;
                  r_act      <= (r_state == S_PLAY);
               end
            end
         end

         assign busy[gi]               = (r_state == S_PLAY);
         assign rom_addr[gi*AW +: AW]  = r_rom_addr;
         assign w_term[gi] = r_act ? SW'($signed(rom_q[gi*24 +: 24])) : '0;
      end
   endgenerate

   logic signed [SW-1:0] w_sum;
   logic signed [SW-1:0] w_shift;
   logic [23:0]          w_sat;

   always_comb begin
      w_sum = '0;
      for (int i = 0; i < NV; i++) w_sum = w_sum + w_term[i];
      w_shift = w_sum <<< GAIN_SHIFT;
      if (w_shift > SAT_HI)      w_sat = 24'h7FFFFF;
      else if (w_shift < SAT_LO) w_sat = 24'h800000;
      else                       w_sat = w_shift[23:0];
   end

   // r_dly[k] marks cycle t+1+k after a tick; rom_q is valid at index ROM_LAT.
   logic [ROM_LAT:0] r_dly;
   logic [23:0]      r_mix;
   logic             r_mix_vld;

   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         r_dly     <= '0;
         r_mix     <= '0;
         r_mix_vld <= 1'b0;
      end else begin
         r_dly     <= {r_dly[ROM_LAT-1:0], w_tick};
         r_mix_vld <= r_dly[ROM_LAT];
         if (r_dly[ROM_LAT]) r_mix <= w_sat;
      end
   end

   logic [23:0]   r_mem [FIFO_DEPTH];
   logic [PW-1:0] r_wr_ptr, r_rd_ptr;
   logic [PW:0]   r_count;
   logic          w_empty, w_full, w_pop, w_push;

   assign w_empty = (r_count == '0);
   assign w_full  = (r_count == (PW+1)'(FIFO_DEPTH));
   assign w_pop   = write_ready & ~w_empty;
   assign w_push  = r_mix_vld & (~w_full | w_pop);

   always_ff @(posedge CLOCK_50) begin
      if (w_push) r_mem[r_wr_ptr] <= r_mix;
   end

   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         overflow <= 1'b0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
         r_count <= r_count + (PW+1)'(w_push) - (PW+1)'(w_pop);
         if (r_mix_vld && w_full && !w_pop) overflow <= 1'b1;
      end
   end

   assign write           = w_pop;
   assign writedata_left  = w_empty ? 24'h0 : r_mem[r_rd_ptr];
   assign writedata_right = writedata_left;

endmodule
